// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter and sequencer that time-shares one sequential 8x8 multiplier
// among N_REQ requesters: latch operands, pulse load, wait for ready (or time out), return product.
module mul_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   a_in,
    input  logic [8*N_REQ-1:0]   b_in,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [15:0]          result,
    output logic                 busy,
    output logic                 mul_load,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic                 mul_ready,
    input  logic [15:0]          mul_out
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, BLANK, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, g, win;
    logic [CW-1:0]   cnt;
    logic            flag, any_req, cnt_last;
    int              idx;

    assign cnt_last = (cnt == CW'(TIMEOUT - 1));

    // Walk from the farthest candidate back to ptr so the one closest to ptr is written last and wins.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                win     = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    state_nxt = BLANK;
            BLANK:   state_nxt = RUN;
            RUN:     if (mul_ready || cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        done     = '0;
        busy     = (state != IDLE);
        mul_load = (state == LOAD);
        err      = (state == DONE) && flag;
        if (state != IDLE) grant[g] = 1'b1;
        if (state == DONE) done[g]  = 1'b1;
    end

    // Ready is ignored in BLANK: the multiplier may still show ready from the previous op.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            g      <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            cnt    <= '0;
            flag   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g     <= win;
                        mul_a <= a_in[{win, 3'b000} +: 8];
                        mul_b <= b_in[{win, 3'b000} +: 8];
                    end
                end
                BLANK: cnt <= '0;
                RUN: begin
                    if (mul_ready) begin
                        result <= mul_out;
                    end else if (cnt_last) begin
                        result <= '0;
                        flag   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    ptr  <= (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
                    flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
